palette_lookup: RTL

Pixel-stream stage directly downstream of the 1024-entry × 16-bit palette memory. Accepts a stream of 10-bit palette indices with a valid/ready handshake, and looks each index up through the palette's second (read-only) port. It expands the RGB565 entry to RGB888 and presents it, with sideband flags, to the display output logic. It also checks line length and flags framing errors.

---
 rtl/palette_lookup.sv | 121 ++++++++++++
 1 files changed

// File: rtl/palette_lookup.sv
// Palette index stream to RGB888 pixel stream, two register stages.
// Looks up RGB565 through the palette read port and checks line framing.
module palette_lookup #(
  parameter int LINE_WIDTH     = 640,
  parameter bit TRANSPARENT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  output logic        inReady,
  input  logic [9:0]  inIndex,
  input  logic        inSof,
  input  logic        inEol,
  output logic [9:0]  palAddr,
  input  logic [15:0] palData,
  output logic        outValid,
  input  logic        outReady,
  output logic [23:0] outRgb,
  output logic        outAlpha,
  output logic        outSof,
  output logic        outEol,
  input  logic        clrErr,
  output logic        lineErr
);

  localparam logic [11:0] LastPos = 12'(LINE_WIDTH - 1);

  logic        s0Valid;
  logic [9:0]  s0Index;
  logic        s0Sof;
  logic        s0Eol;
  logic        s0Alpha;

  logic        advance0;
  logic        advance1;
  logic        inXfer;
  logic        inAlpha;
  logic [23:0] rgbExp;

  logic [11:0] pixCnt;
  logic [11:0] pos;
  logic [11:0] pixCntNext;
  logic        posErr;

  always_comb begin
    advance1 = !outValid || outReady;
    advance0 = !s0Valid || advance1;
    inXfer   = inValid && advance0;
    inAlpha  = !(TRANSPARENT_EN && (inIndex == 10'd0));
  end

  assign inReady = advance0;
  assign palAddr = s0Index;

  // Bit replication keeps full-scale 565 values at full-scale 888.
  assign rgbExp = {
    palData[15:11], palData[15:13],
    palData[10:5],  palData[10:9],
    palData[4:0],   palData[4:2]
  };

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0Valid <= 1'b0;
      s0Index <= '0;
      s0Sof   <= 1'b0;
      s0Eol   <= 1'b0;
      s0Alpha <= 1'b0;
    end else if (inXfer) begin
      s0Valid <= 1'b1;
      s0Index <= inIndex;
      s0Sof   <= inSof;
      s0Eol   <= inEol;
      s0Alpha <= inAlpha;
    end else if (advance0) begin
      s0Valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outValid <= 1'b0;
      outRgb   <= '0;
      outAlpha <= 1'b0;
      outSof   <= 1'b0;
      outEol   <= 1'b0;
    end else if (advance1) begin
      outValid <= s0Valid;
      outRgb   <= rgbExp;
      outAlpha <= s0Alpha;
      outSof   <= s0Valid && s0Sof;
      outEol   <= s0Valid && s0Eol;
    end
  end

  // Position of the pixel being accepted; sof forces it to 0.
  always_comb begin
    pos        = inSof ? 12'd0 : pixCnt;
    pixCntNext = inEol ? 12'd0 : pos + 12'd1;
    posErr     = inEol ? (pos != LastPos) : (pos == LastPos);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixCnt <= '0;
    end else if (inXfer) begin
      pixCnt <= pixCntNext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lineErr <= 1'b0;
    end else if (inXfer && posErr) begin
      lineErr <= 1'b1;
    end else if (clrErr) begin
      lineErr <= 1'b0;
    end
  end

endmodule
